// File: rtl/result_packer_pkg.sv
// Shared constants and elaboration helpers for the result packer and its output FIFO.
package result_packer_pkg;

    localparam int OUT_BITS_DEFAULT = 128;
    localparam int WORDS_OUT_W      = 32;

    function automatic int lanes_of(input int out_bits, input int word_bits);
        return out_bits / word_bits;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Power-of-two depth FIFO with occupancy count; the head word reads as zero while empty.
module stream_fifo #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; it is only observable through o_head, which is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/result_packer.sv
// Packs num_bits result words into OUT_BITS host words, lane 0 in the low bits, and buffers them.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int num_bits   = 32,
    parameter int OUT_BITS   = OUT_BITS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_rdy,
    input  logic [num_bits-1:0]    in_data,
    input  logic                   in_last,
    output logic                   s1o_valid,
    input  logic                   s1o_rdy,
    output logic [OUT_BITS-1:0]    s1o_data,
    output logic [WORDS_OUT_W-1:0] words_out,
    output logic                   busy
);

    localparam int LANES  = lanes_of(OUT_BITS, num_bits);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    if ((num_bits < 1) || (OUT_BITS < num_bits) || (OUT_BITS % num_bits != 0)) begin : g_bad_width
        $error("OUT_BITS must be a non-zero multiple of num_bits");
    end
    if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [LANE_W-1:0]      r_lane;
    logic [OUT_BITS-1:0]    r_assy;
    logic [WORDS_OUT_W-1:0] r_words_out;
    logic [OUT_BITS-1:0]    w_assembled;
    logic                   w_in_fire;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;

    assign in_rdy    = ~w_full;
    assign w_in_fire = in_valid & in_rdy;
    assign w_push    = w_in_fire & ((r_lane == LANE_W'(LANES - 1)) | in_last);
    assign s1o_valid = ~w_empty;
    assign w_pop     = s1o_valid & s1o_rdy;

    // NOTE: default first so every path assigns w_assembled and no latch is inferred.
    always_comb begin
        w_assembled = r_assy;
        w_assembled[int'(r_lane) * num_bits +: num_bits] = in_data;
    end

    // Upper lanes stay zero on an in_last flush because r_assy is cleared after every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_assy <= '0;
        end else if (w_in_fire) begin
            if (w_push) begin
                r_lane <= '0;
                r_assy <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
                r_assy <= w_assembled;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_words_out <= '0;
        else if (w_pop) r_words_out <= r_words_out + 1'b1;
    end

    stream_fifo #(
        .WIDTH (OUT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_assembled),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (s1o_data)
    );

    assign words_out = r_words_out;
    assign busy      = (r_lane != '0) | (w_count != '0);

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal spot checks.
module tb_result_packer;

    localparam int NB    = 32;
    localparam int OB    = 128;
    localparam int FD    = 4;
    localparam int LANES = OB / NB;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [NB-1:0] in_data  = '0;
    logic          s1o_rdy  = 1'b0;
    logic          in_rdy;
    logic          s1o_valid;
    logic [OB-1:0] s1o_data;
    logic [31:0]   words_out;
    logic          busy;

    int checks = 0;
    int errors = 0;

    result_packer #(
        .num_bits   (NB),
        .OUT_BITS   (OB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_last   (in_last),
        .s1o_valid (s1o_valid),
        .s1o_rdy   (s1o_rdy),
        .s1o_data  (s1o_data),
        .words_out (words_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending results and buffered words held as plain queues.
    logic [OB-1:0] m_q[$];
    logic [NB-1:0] m_part[$];
    logic [31:0]   m_words = '0;

    always @(posedge clk or negedge rst_n) begin : model
        logic          do_pop;
        logic          do_acc;
        logic [OB-1:0] word;
        if (!rst_n) begin
            m_q.delete();
            m_part.delete();
            m_words = '0;
        end else begin
            do_pop = s1o_rdy && (m_q.size() != 0);
            do_acc = in_valid && (m_q.size() != FD);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_words = m_words + 1;
            end
            if (do_acc) begin
                m_part.push_back(in_data);
                if ((m_part.size() == LANES) || in_last) begin
                    word = '0;
                    foreach (m_part[i]) word[i*NB +: NB] = m_part[i];
                    m_q.push_back(word);
                    m_part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [OB-1:0] exp_head;
        exp_head = (m_q.size() != 0) ? m_q[0] : '0;
        check("s1o_valid", OB'(s1o_valid), OB'(m_q.size() != 0));
        check("s1o_data",  s1o_data, exp_head);
        check("in_rdy",    OB'(in_rdy), OB'(m_q.size() != FD));
        check("busy",      OB'(busy), OB'((m_q.size() != 0) || (m_part.size() != 0)));
        check("words_out", OB'(words_out), OB'(m_words));
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one result and returns just after the edge that accepted it.
    task automatic send(input logic [NB-1:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_rdy && n < 200) begin
            cycles(1);
            n++;
        end
        check("in_rdy_wait", OB'(in_rdy), OB'(1'b1));
        cycles(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [NB-1:0] base);
        for (int i = 1; i <= LANES; i++) send(base + NB'(i), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(2);
        check("rst_s1o_valid", OB'(s1o_valid), '0);
        check("rst_in_rdy",    OB'(in_rdy), OB'(1'b1));
        check("rst_busy",      OB'(busy), '0);
        check("rst_words_out", OB'(words_out), '0);
        check("rst_s1o_data",  s1o_data, '0);
        rst_n = 1'b1;
        cycles(1);

        // Full word, host ready.
        s1o_rdy = 1'b1;
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b0);
        send(32'h4444_4444, 1'b0);
        check("full_word_valid", OB'(s1o_valid), OB'(1'b1));
        check("full_word_data",  s1o_data, 128'h44444444_33333333_22222222_11111111);
        cycles(1);
        check("full_word_count", OB'(words_out), OB'(32'd1));
        check("full_word_drained", OB'(s1o_valid), '0);

        // Partial flush via in_last.
        send(32'h0000_000A, 1'b0);
        send(32'h0000_000B, 1'b1);
        check("partial_data", s1o_data, 128'h00000000_00000000_0000000B_0000000A);
        check("partial_busy", OB'(busy), OB'(1'b1));
        cycles(1);
        check("partial_busy_drop", OB'(busy), '0);
        check("partial_count", OB'(words_out), OB'(32'd2));

        // Backpressure: 16 results fill the FIFO, the rest wait for the host.
        s1o_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) send(32'h100 + NB'(i), 1'b0);
        check("bp_in_rdy_low", OB'(in_rdy), '0);
        check("bp_head", s1o_data, 128'h00000104_00000103_00000102_00000101);
        in_valid = 1'b1;
        in_data  = 32'h111;
        cycles(3);
        check("bp_still_blocked", OB'(in_rdy), '0);
        s1o_rdy = 1'b1;
        for (int i = 17; i <= 20; i++) send(32'h100 + NB'(i), 1'b0);
        begin
            int n;
            n = 0;
            while ((s1o_valid || busy) && n < 50) begin
                cycles(1);
                n++;
            end
        end
        check("bp_drained_busy", OB'(busy), '0);
        check("bp_count", OB'(words_out), OB'(32'd7));

        // Simultaneous push and pop with one word buffered.
        s1o_rdy = 1'b0;
        send_word(32'h5000_0000);
        send(32'h6000_0001, 1'b0);
        send(32'h6000_0002, 1'b0);
        send(32'h6000_0003, 1'b0);
        check("pp_head_before", s1o_data, 128'h50000004_50000003_50000002_50000001);
        s1o_rdy = 1'b1;
        send(32'h6000_0004, 1'b0);
        check("pp_valid", OB'(s1o_valid), OB'(1'b1));
        check("pp_head_after", s1o_data, 128'h60000004_60000003_60000002_60000001);
        check("pp_count_mid", OB'(words_out), OB'(32'd8));
        cycles(1);
        check("pp_single_word", OB'(s1o_valid), '0);
        check("pp_count_end", OB'(words_out), OB'(32'd9));

        // Reset mid-operation discards lanes and buffered words.
        s1o_rdy = 1'b0;
        send_word(32'h7000_0000);
        send_word(32'h8000_0000);
        send(32'h9000_0001, 1'b0);
        send(32'h9000_0002, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", OB'(s1o_valid), '0);
        check("mid_rst_count", OB'(words_out), '0);
        check("mid_rst_in_rdy", OB'(in_rdy), OB'(1'b1));
        check("mid_rst_busy", OB'(busy), '0);
        cycles(1);
        rst_n   = 1'b1;
        s1o_rdy = 1'b1;
        cycles(1);
        check("post_rst_no_xfer", OB'(words_out), '0);
        send_word(32'hC0DE_0000);
        check("post_rst_word", s1o_data, 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001);
        cycles(1);
        check("post_rst_count", OB'(words_out), OB'(32'd1));

        // words_out wrap from a preloaded value.
        force dut.r_words_out = 32'hFFFF_FFFF;
        m_words = 32'hFFFF_FFFF;
        #1;
        release dut.r_words_out;
        #1;
        check("wrap_preload", OB'(words_out), OB'(32'hFFFF_FFFF));
        send_word(32'hD000_0000);
        cycles(1);
        check("wrap_to_zero", OB'(words_out), '0);

        cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001: Parameter num_bits, default 32, width of one result word from the upstream matrix-vector stage.
REQ-002: Parameter OUT_BITS, default 128, width of the host output stream word.
REQ-003: Parameter FIFO_DEPTH, default 4, number of packed words buffered; power of two, at least 2.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: in_valid  input  1  upstream result valid.
REQ-007: in_rdy  output  1  packer can accept a result this cycle.
REQ-008: in_data  input  num_bits  upstream result word.
REQ-009: in_last  input  1  marks final result of a vector; forces flush of a partial word.
REQ-010: s1o_valid  output  1  output stream word valid.
REQ-011: s1o_rdy  input  1  host output stream ready.
REQ-012: s1o_data  output  OUT_BITS  packed output word.
REQ-013: words_out  output  32  count of output words transferred to host.
REQ-014: busy  output  1  high while any lane is partially filled or the FIFO is non-empty.

Function
REQ-015: LANES = OUT_BITS/num_bits; OUT_BITS shall be an exact multiple of num_bits (elaboration-time check).
REQ-016: Input transfer occurs on a cycle where in_valid and in_rdy are both high; output transfer occurs where s1o_valid and s1o_rdy are both high.
REQ-017: in_rdy = (FIFO occupancy != FIFO_DEPTH); combinational from registered state only, independent of in_valid.
REQ-018: Lane counter starts at 0; each input transfer writes in_data into lane bits [lane*num_bits +: num_bits] and increments lane.
REQ-019: Completion: an input transfer with lane == LANES-1 or in_last == 1 pushes the assembled word (including the current in_data) into the FIFO in the same cycle and resets lane to 0.
REQ-020: On a partial flush via in_last, unfilled upper lanes shall be zero.
REQ-021: Assembly register is cleared to zero after each push.
REQ-022: s1o_valid = FIFO non-empty; s1o_data = FIFO head; head shall remain stable while s1o_valid is high and s1o_rdy low.
REQ-023: Latency: word completed in cycle N appears on s1o_valid/s1o_data in cycle N+1 when the FIFO was empty.
REQ-024: Simultaneous push and pop in one cycle leaves occupancy unchanged; push when FIFO full cannot occur because in_rdy is low.
REQ-025: in_valid with in_rdy low is ignored; no lane, data or counter change.
REQ-026: words_out increments by 1 per output transfer and wraps from 2^32-1 to 0.
REQ-027: Pointers wrap modulo FIFO_DEPTH; occupancy tracked with a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028: On rst_n low, asynchronously: lane=0, assembly register=0, FIFO pointers and count=0, words_out=0; hence s1o_valid=0, busy=0, in_rdy=1, s1o_data=0.
REQ-029: Reset mid-operation shall discard partial lanes and buffered words; no output transfer occurs in the first cycle after rst_n deasserts.

Structure
REQ-030: Shared package holds OUT_BITS default, the LANES derivation function and the words_out width constant.
REQ-031: FIFO shall be a separate sub-module stream_fifo (parameterised width/depth, push/pop/full/empty/count); packer logic stays in result_packer.

Verification
REQ-032: Four results 0x11111111, 0x22222222, 0x33333333, 0x44444444 with s1o_rdy=1 -> one word 0x44444444_33333333_22222222_11111111 one cycle after the fourth, words_out=1.
REQ-033: Two results 0xA, 0xB with in_last on 0xB -> word 0x0..0_0000000B_0000000A, lane returns to 0, busy drops after transfer.
REQ-034: s1o_rdy=0, stream 20 results -> in_rdy drops after 16 accepted (4 words buffered); raising s1o_rdy drains 4 words in order, then remaining 4 results accepted.
REQ-035: FIFO holding one word, s1o_rdy=1 and fourth lane accepted same cycle -> occupancy stays 1, no word lost or duplicated.
REQ-036: Assert rst_n low after 2 lanes filled and 2 words buffered -> s1o_valid=0, words_out=0, in_rdy=1 immediately; next 4 results form a clean word.
REQ-037: Preload words_out near wrap via 2^32 transfers (or forced state) -> increments 0xFFFFFFFF to 0x00000000.
